i2c_reg_target: RTL and testbench

Register-file I2C target (slave) modelling the image sensor's configuration port at 7-bit address 0x37 (0x6E write / 0x6F read). It sits on the bench side of the SCL/SDA bus, opposite the sensor register-programming controller and its I2C master. It accepts register writes and random/sequential reads, holds a 256×8 register file, and reports every committed write on a strobe port so the sensor model and the bench scoreboard can track programming order.

---
 rtl/i2c_reg_target_if.sv | 21 ++
 rtl/i2c_reg_target.sv | 192 +++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_target_if.sv
// Bus-side bundle for the I2C register target: SCL/SDA levels, open-drain SDA
// enable, and the committed-write strobe port.
interface i2c_reg_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, wr_en, wr_addr, wr_data, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register-file target at a fixed 7-bit address: pointer write, data writes
// with a commit strobe, and random/sequential reads from a 256x8 register file.
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR = 7'h37
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_reg_target_if.slave   bus
);
    localparam int unsigned RF_DEPTH = 256;
    localparam int unsigned SYNC_W   = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_REG, S_REG_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t              state;
    logic [SYNC_W-1:0]   scl_sync;
    logic [SYNC_W-1:0]   sda_sync;
    logic [7:0]          regfile [RF_DEPTH];
    logic [7:0]          shreg;
    logic [7:0]          rd_shreg;
    logic [7:0]          ptr;
    logic [2:0]          bit_cnt;
    logic                rw;
    logic                commit_pend;
    logic                sda_oe;
    logic                wr_en;
    logic [7:0]          wr_addr;
    logic [7:0]          wr_data;
    logic                busy;

    logic                scl, sda, scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0]          rx_byte;

    // Two synchronizer flops, third flop holds the previous level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_W-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_W-2:0], bus.sda_in};
        end
    end

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  =  scl & ~scl_sync[2];
    assign scl_fall  = ~scl &  scl_sync[2];
    assign start_det =  scl &  scl_sync[2] & ~sda &  sda_sync[2];
    assign stop_det  =  scl &  scl_sync[2] &  sda & ~sda_sync[2];
    assign rx_byte   = {shreg[6:0], sda};
    assign last_bit  = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            rd_shreg    <= '0;
            ptr         <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            commit_pend <= 1'b0;
            sda_oe      <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            for (int unsigned i = 0; i < RF_DEPTH; i++) begin
                regfile[8'(i)] <= '0;
            end
        end else begin
            wr_en <= 1'b0;

            // Commit lands one clk after the final data bit was sampled
            if (commit_pend) begin
                regfile[ptr] <= shreg;
                wr_en        <= 1'b1;
                wr_addr      <= ptr;
                wr_data      <= shreg;
                ptr          <= ptr + 8'd1;
                commit_pend  <= 1'b0;
            end

            if (stop_det) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= S_DEV;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE, S_IGNORE: sda_oe <= 1'b0;

                    S_DEV: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= 3'(bit_cnt + 3'd1);
                            if (last_bit) begin
                                rw    <= sda;
                                state <= (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
                            end
                        end
                    end

                    S_REG: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= 3'(bit_cnt + 3'd1);
                            if (last_bit) begin
                                ptr   <= rx_byte;
                                state <= S_REG_ACK;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= 3'(bit_cnt + 3'd1);
                            if (last_bit) begin
                                commit_pend <= 1'b1;
                                state       <= S_WR_ACK;
                            end
                        end
                    end

                    // ACK pulls on the fall after bit 8; the next state releases on the following fall
                    S_DEV_ACK: begin
                        if (scl_fall) sda_oe <= 1'b1;
                        if (scl_rise) begin
                            if (rw) begin
                                rd_shreg <= regfile[ptr];
                                state    <= S_RD_DATA;
                            end else begin
                                state    <= S_REG;
                            end
                        end
                    end

                    S_REG_ACK, S_WR_ACK: begin
                        if (scl_fall) sda_oe <= 1'b1;
                        if (scl_rise) state <= S_WR_DATA;
                    end

                    S_RD_DATA: begin
                        if (scl_fall) begin
                            sda_oe   <= ~rd_shreg[7];
                            rd_shreg <= {rd_shreg[6:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bit_cnt <= 3'(bit_cnt + 3'd1);
                            if (last_bit) begin
                                ptr   <= ptr + 8'd1;
                                state <= S_RD_ACK;
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            if (!sda) begin
                                rd_shreg <= regfile[ptr];
                                state    <= S_RD_DATA;
                            end else begin
                                state    <= S_IGNORE;
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe  = sda_oe;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, register-file model with an
// expected-commit queue, and a per-cycle compare process.
module tb_i2c_reg_target;
    localparam int unsigned Q = 8;  // clk cycles per quarter SCL period

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_reg_target_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_reg_target dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mrf [256];
    logic [7:0] mptr     = 8'h00;
    wr_t        exp_q [$];
    wr_t        log_q [$];
    wr_t        last_wr  = '0;
    wr_t        e;
    logic [7:0] dq [$];
    logic [7:0] rd;
    bit         quiet    = 1'b0;
    bit         busy_chk = 1'b0;
    bit         exp_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the strobe port, busy and forced-quiet SDA
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en === 1'b1) begin
                log_q.push_back({bus.wr_addr, bus.wr_data});
                if (exp_q.size() == 0) begin
                    chk("wr_en_unexpected", 32'(bus.wr_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_commit", 32'({bus.wr_addr, bus.wr_data}), 32'(e));
                    last_wr = e;
                end
            end else begin
                chk("wr_hold", 32'({bus.wr_addr, bus.wr_data}), 32'(last_wr));
            end
            if (busy_chk) chk("busy", 32'(bus.busy), 32'(exp_busy));
            if (quiet)    chk("quiet_sda_oe", 32'(bus.sda_oe), 32'd0);
        end
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic drive, output logic s);
        sda_m = drive;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        s = bus.sda_in;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        busy_chk = 1'b0;
        sda_m = 1'b0;
        wait_clk(Q);
        exp_busy = 1'b1;
        busy_chk = 1'b1;
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        busy_chk = 1'b0;
        sda_m = 1'b1;
        wait_clk(Q);
        exp_busy = 1'b0;
        busy_chk = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s;
        send_bits(b);
        bit_cycle(1'b1, s);
        chk(name, 32'(s), exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack ? 1'b0 : 1'b1, s);
    endtask

    // Full write transaction; the model records what each data byte must commit
    task automatic do_write(input logic [7:0] ra, input string tag);
        start_c();
        send_byte(8'h6E, 1'b1, {tag, "_ack_dev"});
        send_byte(ra, 1'b1, {tag, "_ack_reg"});
        mptr = ra;
        foreach (dq[i]) begin
            exp_q.push_back({mptr, dq[i]});
            mrf[mptr] = dq[i];
            mptr = mptr + 8'd1;
            send_byte(dq[i], 1'b1, {tag, "_ack_data"});
        end
        stop_c();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mrf[i]) mrf[i] = 8'h00;
        wait_clk(3);
        chk("rst_sda_oe",  32'(bus.sda_oe),  32'd0);
        chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        rst_n = 1'b1;
        wait_clk(4);
        busy_chk = 1'b1;

        // Single write
        log_q.delete();
        dq = {8'h00};
        do_write(8'h40, "t1");
        chk("t1_count", 32'(log_q.size()), 32'd1);
        chk("t1_commit", 32'(log_q[0]), 32'h4000);

        // Burst write
        log_q.delete();
        dq = {8'h30, 8'h73, 8'hAF};
        do_write(8'h30, "t2");
        chk("t2_count", 32'(log_q.size()), 32'd3);
        chk("t2_c0", 32'(log_q[0]), 32'h3030);
        chk("t2_c1", 32'(log_q[1]), 32'h3173);
        chk("t2_c2", 32'(log_q[2]), 32'h32AF);

        // Foreign address 0x70: never acknowledged, never driven
        log_q.delete();
        quiet = 1'b1;
        start_c();
        send_byte(8'hE0, 1'b0, "t3_nack_addr");
        send_byte(8'h12, 1'b0, "t3_nack_data");
        stop_c();
        quiet = 1'b0;
        chk("t3_count", 32'(log_q.size()), 32'd0);

        // Pointer wrap
        log_q.delete();
        dq = {8'h11, 8'h22};
        do_write(8'hFF, "t4");
        chk("t4_count", 32'(log_q.size()), 32'd2);
        chk("t4_c0", 32'(log_q[0]), 32'hFF11);
        chk("t4_c1", 32'(log_q[1]), 32'h0022);

        // Marker byte at 0x33 to prove where the pointer lands after reads
        log_q.delete();
        dq = {8'h5A};
        do_write(8'h33, "t5");
        chk("t5_commit", 32'(log_q[0]), 32'h335A);

        // Random read with repeated start, sequential second byte, master NACK
        start_c();
        send_byte(8'h6E, 1'b1, "t6_ack_dev");
        send_byte(8'h31, 1'b1, "t6_ack_reg");
        mptr = 8'h31;
        start_c();
        send_byte(8'h6F, 1'b1, "t6_ack_devrd");
        read_byte(1'b1, rd);
        chk("t6_rd0_model", 32'(rd), 32'(mrf[mptr]));
        chk("t6_rd0", 32'(rd), 32'h73);
        mptr = mptr + 8'd1;
        read_byte(1'b0, rd);
        chk("t6_rd1_model", 32'(rd), 32'(mrf[mptr]));
        chk("t6_rd1", 32'(rd), 32'hAF);
        mptr = mptr + 8'd1;
        chk("t6_oe_after_nack", 32'(bus.sda_oe), 32'd0);
        quiet = 1'b1;
        stop_c();
        quiet = 1'b0;

        // Current-address read: pointer must have stopped at 0x33
        start_c();
        send_byte(8'h6F, 1'b1, "t7_ack_devrd");
        read_byte(1'b0, rd);
        chk("t7_rd_model", 32'(rd), 32'(mrf[mptr]));
        chk("t7_rd_ptr", 32'(rd), 32'h5A);
        mptr = mptr + 8'd1;
        stop_c();

        // STOP after four data bits: no commit, back to idle
        log_q.delete();
        start_c();
        send_byte(8'h6E, 1'b1, "t8_ack_dev");
        send_byte(8'h50, 1'b1, "t8_ack_reg");
        mptr = 8'h50;
        begin
            logic s;
            bit_cycle(1'b1, s);
            bit_cycle(1'b0, s);
            bit_cycle(1'b1, s);
            bit_cycle(1'b0, s);
        end
        stop_c();
        chk("t8_no_commit", 32'(log_q.size()), 32'd0);
        dq = {8'h99};
        do_write(8'h50, "t8b");
        chk("t8_after_abort", 32'(log_q[0]), 32'h5099);

        // Reset during the address ACK low phase
        start_c();
        send_bits(8'h6E);
        chk("t9_ack_driven", 32'(bus.sda_oe), 32'd1);
        busy_chk = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t9_oe_async", 32'(bus.sda_oe), 32'd0);
        chk("t9_busy_async", 32'(bus.busy), 32'd0);
        chk("t9_wr_addr_rst", 32'(bus.wr_addr), 32'd0);
        foreach (mrf[i]) mrf[i] = 8'h00;
        mptr = 8'h00;
        exp_q.delete();
        last_wr = '0;
        exp_busy = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        busy_chk = 1'b1;

        // Register 0x00 held 0x22 before reset; it must read back cleared
        start_c();
        send_byte(8'h6F, 1'b1, "t10_ack_devrd");
        read_byte(1'b0, rd);
        chk("t10_rd_model", 32'(rd), 32'(mrf[mptr]));
        chk("t10_rd_cleared", 32'(rd), 32'h00);
        stop_c();

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
